multicycle_decoder: RTL and testbench

MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

---
 rtl/multicycle_decoder_pkg.sv | 49 ++++
 rtl/alu_decoder.sv | 51 +++++
 rtl/multicycle_decoder.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_decoder_pkg.sv
// Shared state type, ALU opcodes, cmd encodings and instruction qualifiers for
// the multicycle main decoder and its ALU decoder.
package multicycle_decoder_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_MULWAIT,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_MUL   = 3'b100;
    localparam logic [2:0] ALU_MOV   = 3'b101;
    localparam logic [2:0] ALU_MOVHI = 3'b110;

    localparam logic [3:0] CMD_AND   = 4'b0000;
    localparam logic [3:0] CMD_SUB   = 4'b0010;
    localparam logic [3:0] CMD_ADD   = 4'b0100;
    localparam logic [3:0] CMD_MOVW  = 4'b1000;
    localparam logic [3:0] CMD_CMP   = 4'b1010;
    localparam logic [3:0] CMD_ORR   = 4'b1100;
    localparam logic [3:0] CMD_MOVHI = 4'b1101;

    localparam logic [3:0] MUL_QUAL   = 4'b1001;
    localparam logic [3:0] MOVHI_QUAL = 4'b1000;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] IMM_DP   = 2'b00;
    localparam logic [1:0] IMM_MEM  = 2'b01;
    localparam logic [1:0] IMM_BR   = 2'b10;
    localparam logic [1:0] IMM_MOVW = 2'b11;

    localparam logic [3:0] PC_REG = 4'b1111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of a data-processing instruction into ALU operation,
// flag-write enables, NoWrite and the DP immediate format.
module alu_decoder
    import multicycle_decoder_pkg::*;
(
    input  logic [3:0] cmd,
    input  logic       imm,
    input  logic       s,
    input  logic [3:0] mul,
    input  logic [3:0] movhi,
    output logic [2:0] alu_op,
    output logic       no_write,
    output logic [1:0] imm_src,
    output logic [1:0] flag_w,
    output logic       is_mul
);

    always_comb begin
        alu_op   = ALU_ADD;
        no_write = 1'b0;
        imm_src  = IMM_DP;
        is_mul   = 1'b0;
        case (cmd)
            CMD_ADD: alu_op = ALU_ADD;
            CMD_SUB: alu_op = ALU_SUB;
            CMD_AND: begin
                if (mul == MUL_QUAL) begin
                    alu_op = ALU_MUL;
                    is_mul = !imm;
                end else begin
                    alu_op = ALU_AND;
                end
            end
            CMD_ORR: alu_op = ALU_ORR;
            CMD_CMP: begin
                alu_op   = ALU_SUB;
                no_write = 1'b1;
            end
            CMD_MOVHI: alu_op = (!imm && movhi == MOVHI_QUAL) ? ALU_MOVHI : ALU_MOV;
            CMD_MOVW: begin
                alu_op  = ALU_MOV;
                imm_src = IMM_MOVW;
            end
            default: ;
        endcase
    end

    // Carry/overflow flags only mean something for arithmetic operations.
    assign flag_w = {s, s && (alu_op == ALU_ADD || alu_op == ALU_SUB)};

endmodule

// File: rtl/multicycle_decoder.sv
// Main controller for a multicycle ARM-style datapath: sequences fetch, decode,
// memory, execute and writeback, with a down-counter stretching MUL execution.
//
// state     | meaning
// ----------+------------------------------------------------------------
// FETCH     | read instruction; IR and PC load when memory is ready
// DECODE    | read registers, PC+4 on the ALU, pick instruction class
// MEMADR    | compute load/store address
// MEMRD     | load access, held until mem_ready
// MEMWB     | write loaded data to the register file
// MEMWR     | store access, MemW held until mem_ready
// EXECR     | data-processing with register operand
// EXECI     | data-processing with immediate operand
// MULWAIT   | MUL latency; counter runs down to zero
// ALUWB     | write ALU result and flags
// BRANCH    | load branch target into the PC
module multicycle_decoder
    import multicycle_decoder_pkg::*;
#(
    parameter int MUL_LAT  = 3,
    parameter int ALUCTL_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          Op,
    input  logic [5:0]          Funct,
    input  logic [3:0]          Rd,
    input  logic [3:0]          Mul,
    input  logic [3:0]          movhi,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                AdrSrc,
    output logic                RegW,
    output logic                MemW,
    output logic                NoWrite,
    output logic                busy,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ImmSrc,
    output logic [1:0]          RegSrc,
    output logic [1:0]          FlagW,
    output logic [ALUCTL_W-1:0] ALUControl
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] mul_cnt, mul_cnt_nxt;
    logic       rst_q;
    logic       dp_state;

    logic [2:0] dec_alu_op;
    logic       dec_no_write;
    logic [1:0] dec_imm_src;
    logic [1:0] dec_flag_w;
    logic       dec_is_mul;

    alu_decoder u_alu_decoder (
        .cmd      (Funct[4:1]),
        .imm      (Funct[5]),
        .s        (Funct[0]),
        .mul      (Mul),
        .movhi    (movhi),
        .alu_op   (dec_alu_op),
        .no_write (dec_no_write),
        .imm_src  (dec_imm_src),
        .flag_w   (dec_flag_w),
        .is_mul   (dec_is_mul)
    );

    // rst_q keeps every output quiet in the cycle(s) after a reset edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_FETCH;
            mul_cnt <= 4'd0;
            rst_q   <= 1'b1;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
            rst_q   <= 1'b0;
        end
    end

    assign dp_state = state inside {S_EXECR, S_EXECI, S_MULWAIT, S_ALUWB};

    always_comb begin
        state_nxt   = state;
        mul_cnt_nxt = mul_cnt;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        AdrSrc      = 1'b0;
        RegW        = 1'b0;
        MemW        = 1'b0;
        NoWrite     = 1'b0;
        busy        = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ImmSrc      = 2'b00;
        RegSrc      = 2'b00;
        FlagW       = 2'b00;
        ALUControl  = '0;
        if (!rst_q) begin
            busy = (state != S_FETCH);
            if (state != S_FETCH)
                RegSrc = {(Op == OP_MEM) && !Funct[0], Op == OP_BR};
            // ALU selects stay on the decoded operation for the whole DP sequence.
            if (dp_state) begin
                ALUSrcB    = {1'b0, Funct[5]};
                ALUControl = ALUCTL_W'(dec_alu_op);
                ImmSrc     = dec_imm_src;
                NoWrite    = dec_no_write;
            end
            case (state)
                S_FETCH: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                    if (mem_ready) state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    case (Op)
                        OP_MEM:  state_nxt = S_MEMADR;
                        OP_BR:   state_nxt = S_BRANCH;
                        OP_DP:   state_nxt = Funct[5] ? S_EXECI : S_EXECR;
                        default: state_nxt = S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcB   = 2'b01;
                    ImmSrc    = IMM_MEM;
                    state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    AdrSrc = 1'b1;
                    if (mem_ready) state_nxt = S_MEMWB;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                    PCWrite   = (Rd == PC_REG);
                    state_nxt = S_FETCH;
                end
                S_MEMWR: begin
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                    if (mem_ready) state_nxt = S_FETCH;
                end
                S_EXECR, S_EXECI: begin
                    if (dec_is_mul) begin
                        state_nxt   = S_MULWAIT;
                        mul_cnt_nxt = MUL_LOAD;
                    end else begin
                        state_nxt = S_ALUWB;
                    end
                end
                S_MULWAIT: begin
                    if (mul_cnt == 4'd0) state_nxt = S_ALUWB;
                    else                 mul_cnt_nxt = mul_cnt - 4'd1;
                end
                S_ALUWB: begin
                    ResultSrc = 2'b00;
                    RegW      = !dec_no_write;
                    PCWrite   = !dec_no_write && (Rd == PC_REG);
                    FlagW     = dec_flag_w;
                    state_nxt = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                    ImmSrc    = IMM_BR;
                    state_nxt = S_FETCH;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_decoder.sv
// Directed bench for multicycle_decoder: table of DP instructions plus
// hand-written memory, branch, MUL-latency and reset-abort sequences.
module tb_multicycle_decoder;

    typedef struct packed {
        logic       pcw, irw, adr, regw, memw, nowr, busy;
        logic [1:0] res, srca, srcb, imm, regsrc, flagw;
        logic [2:0] alu;
    } outs_t;

    typedef struct packed {
        logic [5:0] funct;
        logic [3:0] rd, mul, movhi;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic       nowr;
        logic [1:0] imm, flagw;
        logic       regw, pcw;
        logic [3:0] waits;
    } dp_vec_t;

    logic       clk;
    logic       reset, reset_2;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd, Mul, movhi;
    logic       mem_ready, mem_ready_2;

    logic       PCWrite, IRWrite, AdrSrc, RegW, MemW, NoWrite, busy;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, FlagW;
    logic [2:0] ALUControl;

    logic       PCWrite_2, IRWrite_2, AdrSrc_2, RegW_2, MemW_2, NoWrite_2, busy_2;
    logic [1:0] ResultSrc_2, ALUSrcA_2, ALUSrcB_2, ImmSrc_2, RegSrc_2, FlagW_2;
    logic [3:0] ALUControl_2;

    outs_t cur, cur_2;
    int    n_checks = 0;
    int    n_fail   = 0;
    dp_vec_t vecs [15];

    multicycle_decoder #(.MUL_LAT(3), .ALUCTL_W(3)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Mul(Mul),
        .movhi(movhi), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .busy(busy), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .FlagW(FlagW), .ALUControl(ALUControl)
    );

    // Second instance: shortest MUL latency and a widened ALUControl.
    multicycle_decoder #(.MUL_LAT(1), .ALUCTL_W(4)) dut_2 (
        .clk(clk), .reset(reset_2), .Op(Op), .Funct(Funct), .Rd(Rd), .Mul(Mul),
        .movhi(movhi), .mem_ready(mem_ready_2),
        .PCWrite(PCWrite_2), .IRWrite(IRWrite_2), .AdrSrc(AdrSrc_2), .RegW(RegW_2),
        .MemW(MemW_2), .NoWrite(NoWrite_2), .busy(busy_2), .ResultSrc(ResultSrc_2),
        .ALUSrcA(ALUSrcA_2), .ALUSrcB(ALUSrcB_2), .ImmSrc(ImmSrc_2), .RegSrc(RegSrc_2),
        .FlagW(FlagW_2), .ALUControl(ALUControl_2)
    );

    assign cur   = {PCWrite, IRWrite, AdrSrc, RegW, MemW, NoWrite, busy,
                    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, FlagW, ALUControl};
    assign cur_2 = {PCWrite_2, IRWrite_2, AdrSrc_2, RegW_2, MemW_2, NoWrite_2, busy_2,
                    ResultSrc_2, ALUSrcA_2, ALUSrcB_2, ImmSrc_2, RegSrc_2, FlagW_2,
                    ALUControl_2[2:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // st = {pcw, irw, adr, regw, memw, nowr, busy}
    function automatic outs_t mk(input logic [6:0] st, input logic [1:0] res, srca, srcb,
                                 imm, rsrc, flg, input logic [2:0] alu);
        return {st, res, srca, srcb, imm, rsrc, flg, alu};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input outs_t got, input outs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    function automatic outs_t fetch_o(input logic rdy);
        return mk({rdy, rdy, 5'b00000}, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000);
    endfunction

    function automatic outs_t decode_o(input logic [1:0] rs);
        return mk(7'b0000001, 2'b10, 2'b01, 2'b10, 2'b00, rs, 2'b00, 3'b000);
    endfunction

    function automatic outs_t memadr_o(input logic [1:0] rs);
        return mk(7'b0000001, 2'b00, 2'b00, 2'b01, 2'b01, rs, 2'b00, 3'b000);
    endfunction

    task automatic run_dp(input int idx, input dp_vec_t v);
        outs_t ex, wb;
        ex = mk({5'b00000, v.nowr, 1'b1}, 2'b00, 2'b00, v.srcb, v.imm, 2'b00, 2'b00, v.alu);
        wb = mk({v.pcw, 2'b00, v.regw, 1'b0, v.nowr, 1'b1}, 2'b00, 2'b00, v.srcb, v.imm,
                2'b00, v.flagw, v.alu);
        Op = 2'b00; Funct = v.funct; Rd = v.rd; Mul = v.mul; movhi = v.movhi;
        mem_ready = 1'b1;
        #1 check($sformatf("dp%0d fetch", idx), cur, fetch_o(1'b1));
        tick(); mem_ready = 1'b0;
        #1 check($sformatf("dp%0d decode", idx), cur, decode_o(2'b00));
        tick();
        #1 check($sformatf("dp%0d exec", idx), cur, ex);
        for (int i = 0; i < int'(v.waits); i++) begin
            tick();
            #1 check($sformatf("dp%0d mulwait%0d", idx, i), cur, ex);
        end
        tick();
        #1 check($sformatf("dp%0d aluwb", idx), cur, wb);
        tick();
        #1 check($sformatf("dp%0d next fetch", idx), cur, fetch_o(1'b0));
    endtask

    task automatic run_ldr(input string name, input logic [3:0] rd, input int stalls,
                           input logic pcw);
        Op = 2'b01; Funct = 6'b011001; Rd = rd; Mul = 4'd0; movhi = 4'd0;
        mem_ready = 1'b1;
        #1 check({name, " fetch"}, cur, fetch_o(1'b1));
        tick();
        #1 check({name, " decode"}, cur, decode_o(2'b00));
        tick();
        #1 check({name, " memadr"}, cur, memadr_o(2'b00));
        for (int i = 0; i < stalls; i++) begin
            tick(); mem_ready = 1'b0;
            #1 check($sformatf("%s memrd stall%0d", name, i), cur,
                     mk(7'b0010001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        end
        tick(); mem_ready = 1'b1;
        #1 check({name, " memrd done"}, cur,
                 mk(7'b0010001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        tick(); mem_ready = 1'b0;
        #1 check({name, " memwb"}, cur,
                 mk({pcw, 6'b001001}, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        tick();
        #1 check({name, " next fetch"}, cur, fetch_o(1'b0));
    endtask

    task automatic run_str(input string name, input int stalls, input logic abort);
        outs_t wr;
        wr = mk(7'b0010101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000);
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd3; Mul = 4'd0; movhi = 4'd0;
        mem_ready = 1'b1;
        #1 check({name, " fetch"}, cur, fetch_o(1'b1));
        tick();
        #1 check({name, " decode"}, cur, decode_o(2'b10));
        tick();
        #1 check({name, " memadr"}, cur, memadr_o(2'b10));
        for (int i = 0; i < stalls; i++) begin
            tick(); mem_ready = 1'b0;
            #1 check($sformatf("%s memwr stall%0d", name, i), cur, wr);
        end
        if (abort) begin
            reset = 1'b0;
            tick();
            #1 check({name, " reset abort"}, cur, '0);
            mem_ready = 1'b1;
            tick();
            #1 check({name, " reset hold"}, cur, '0);
            reset = 1'b1; mem_ready = 1'b0;
            tick();
            #1 check({name, " after reset"}, cur, fetch_o(1'b0));
        end else begin
            tick(); mem_ready = 1'b1;
            #1 check({name, " memwr done"}, cur, wr);
            tick(); mem_ready = 1'b0;
            #1 check({name, " next fetch"}, cur, fetch_o(1'b0));
        end
    endtask

    initial begin
        //         funct      rd     mul      movhi    srcb   alu     nw    imm    flg    rw    pcw   waits
        vecs[0]  = '{6'b001001, 4'd1,  4'b0000, 4'b0000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 4'd0}; // ADDS
        vecs[1]  = '{6'b100101, 4'd2,  4'b0000, 4'b0000, 2'b01, 3'b001, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 4'd0}; // SUBS imm
        vecs[2]  = '{6'b000001, 4'd3,  4'b0000, 4'b0000, 2'b00, 3'b010, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 4'd0}; // ANDS
        vecs[3]  = '{6'b111000, 4'd4,  4'b0000, 4'b0000, 2'b01, 3'b011, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'd0}; // ORR imm
        vecs[4]  = '{6'b010101, 4'd0,  4'b0000, 4'b0000, 2'b00, 3'b001, 1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 4'd0}; // CMP
        vecs[5]  = '{6'b011010, 4'd5,  4'b0000, 4'b1000, 2'b00, 3'b110, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'd0}; // MOVHI
        vecs[6]  = '{6'b111010, 4'd5,  4'b0000, 4'b1000, 2'b01, 3'b101, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'd0}; // MOV imm
        vecs[7]  = '{6'b011010, 4'd6,  4'b0000, 4'b1110, 2'b00, 3'b101, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'd0}; // MOV reg
        vecs[8]  = '{6'b110000, 4'd7,  4'b0000, 4'b0000, 2'b01, 3'b101, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 4'd0}; // MOVW
        vecs[9]  = '{6'b001000, 4'd15, 4'b0000, 4'b0000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 4'd0}; // ADD pc
        vecs[10] = '{6'b010101, 4'd15, 4'b0000, 4'b0000, 2'b00, 3'b001, 1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 4'd0}; // CMP rd=pc
        vecs[11] = '{6'b000010, 4'd8,  4'b0000, 4'b0000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'd0}; // other cmd
        vecs[12] = '{6'b100000, 4'd9,  4'b1001, 4'b0000, 2'b01, 3'b100, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'd0}; // imm, no MULWAIT
        vecs[13] = '{6'b000001, 4'd10, 4'b1001, 4'b0000, 2'b00, 3'b100, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 4'd3}; // MULS
        vecs[14] = '{6'b000000, 4'd15, 4'b1001, 4'b0000, 2'b00, 3'b100, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 4'd3}; // MUL pc

        reset = 1'b0; reset_2 = 1'b0; mem_ready = 1'b1; mem_ready_2 = 1'b0;
        Op = 2'b00; Funct = 6'd0; Rd = 4'd0; Mul = 4'd0; movhi = 4'd0;
        tick(); tick();
        #1 check("reset state", cur, '0);

        reset = 1'b1; mem_ready = 1'b0;
        tick();
        #1 check("fetch after reset", cur, fetch_o(1'b0));
        tick();
        #1 check("fetch stall", cur, fetch_o(1'b0));

        for (int i = 0; i < 15; i++) run_dp(i, vecs[i]);

        run_ldr("ldr stall", 4'd2, 2, 1'b0);
        run_ldr("ldr pc", 4'd15, 0, 1'b1);
        run_str("str", 1, 1'b0);
        run_str("str abort", 2, 1'b1);

        Op = 2'b10; Funct = 6'b100000; Rd = 4'd0; Mul = 4'd0; mem_ready = 1'b1;
        #1 check("b fetch", cur, fetch_o(1'b1));
        tick(); mem_ready = 1'b0;
        #1 check("b decode", cur, decode_o(2'b01));
        tick();
        #1 check("b branch", cur,
                 mk(7'b1000001, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 3'b000));
        tick();
        #1 check("b next fetch", cur, fetch_o(1'b0));

        Op = 2'b11; Funct = 6'b001001; mem_ready = 1'b1;
        #1 check("op11 fetch", cur, fetch_o(1'b1));
        tick(); mem_ready = 1'b0;
        #1 check("op11 decode", cur, decode_o(2'b00));
        tick();
        #1 check("op11 back to fetch", cur, fetch_o(1'b0));

        // Abort a MUL in MULWAIT, then confirm a following MUL runs its full latency.
        Op = 2'b00; Funct = 6'b000001; Rd = 4'd4; Mul = 4'b1001; mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
        tick(); tick();
        #1 check("mul abort in mulwait", cur,
                 mk(7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100));
        reset = 1'b0;
        tick();
        #1 check("mul abort reset", cur, '0);
        reset = 1'b1;
        tick();
        #1 check("mul abort fetch", cur, fetch_o(1'b0));
        run_dp(99, vecs[13]);

        // MUL_LAT=1 instance: exactly one MULWAIT cycle, ALUControl zero-extended.
        Op = 2'b00; Funct = 6'b000001; Rd = 4'd1; Mul = 4'b1001; movhi = 4'd0;
        reset_2 = 1'b1;
        tick();
        #1 check("lat1 fetch idle", cur_2, fetch_o(1'b0));
        mem_ready_2 = 1'b1;
        #1 check("lat1 fetch", cur_2, fetch_o(1'b1));
        tick(); mem_ready_2 = 1'b0;
        #1 check("lat1 decode", cur_2, decode_o(2'b00));
        tick();
        #1 check("lat1 execr", cur_2,
                 mk(7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100));
        tick();
        #1 check("lat1 mulwait", cur_2,
                 mk(7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100));
        tick();
        #1 check("lat1 aluwb", cur_2,
                 mk(7'b0001001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 3'b100));
        n_checks++;
        if (ALUControl_2 !== 4'b0100) begin
            n_fail++;
            $display("FAIL lat1 aluctl width: got %b required %b", ALUControl_2, 4'b0100);
        end
        tick();
        #1 check("lat1 next fetch", cur_2, fetch_o(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
